// File: rtl/calc_result_bcd.sv
// calc_result_bcd: converts an unsigned binary magnitude plus sign flag into
// packed BCD using a sequential double-dabble (add-3 / shift-left) engine.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   RESULT/NEG are valid for conversion
//   in_ready   out  high only while idle; accept happens on in_valid && in_ready
//   RESULT     in   WIDTH-bit unsigned magnitude
//   NEG        in   sign of RESULT (1 = negative)
//   bcd_out    out  packed BCD, digit 0 (units) in [3:0]
//   sign_out   out  sign of the converted value; negative zero reported as +0
//   out_valid  out  one-cycle strobe when bcd_out/sign_out were just updated
//   blank_out  out  leading-zero blank mask (only when CALC_BCD_LZB_EN is defined)
//
// Optional feature macro: CALC_BCD_LZB_EN adds the blank_out port and logic.

module calc_result_bcd #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      RESULT,
    input  logic                  NEG,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  out_valid
`ifdef CALC_BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]     blank_out
`endif
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = BW + WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     shreg_q;
    logic [SW-1:0]     shreg_adj;
    logic [SW-1:0]     shreg_d;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic [BW-1:0]     bcd_q;
    logic              sign_q;
    logic              valid_q;
    logic              ready_q;
    logic [BW-1:0]     bcd_field;

    assign bcd_field = shreg_q[WIDTH +: BW];

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        shreg_adj = shreg_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shreg_q[WIDTH + 4*i +: 4] >= 4'd5) begin
                shreg_adj[WIDTH + 4*i +: 4] = shreg_q[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        shreg_d = {shreg_adj[SW-2:0], 1'b0};
    end

`ifdef CALC_BCD_LZB_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_d;

    // A digit is blanked when it and every digit above it are zero; units never blank.
    always_comb begin
        blank_d = '0;
        blank_d[DIGITS-1] = (bcd_field[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = int'(DIGITS) - 2; i >= 1; i--) begin
            blank_d[i] = blank_d[i+1] && (bcd_field[4*i +: 4] == 4'd0);
        end
        blank_d[0] = 1'b0;
    end

    assign blank_out = blank_q;
`endif

    // Control FSM and all output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef CALC_BCD_LZB_EN
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && ready_q) begin
                        shreg_q <= {{BW{1'b0}}, RESULT};
                        neg_q   <= NEG;
                        cnt_q   <= CW'(WIDTH);
                        ready_q <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_q   <= bcd_field;
                    sign_q  <= neg_q && (bcd_field != '0);
`ifdef CALC_BCD_LZB_EN
                    blank_q <= blank_d;
`endif
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign bcd_out   = bcd_q;
    assign sign_out  = sign_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_calc_result_bcd.sv
// Testbench for calc_result_bcd: scoreboard of expected conversions pushed at
// accept time and popped when out_valid strobes.

module tb_calc_result_bcd;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] RESULT;
    logic        NEG;
    logic [19:0] bcd_out;
    logic        sign_out;
    logic        out_valid;
`ifdef CALC_BCD_LZB_EN
    logic [4:0]  blank_out;
`endif

    typedef struct {
        int          val;
        logic [19:0] bcd;
        logic        sign;
        logic [4:0]  blank;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    calc_result_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .RESULT    (RESULT),
        .NEG       (NEG),
        .bcd_out   (bcd_out),
        .sign_out  (sign_out),
        .out_valid (out_valid)
`ifdef CALC_BCD_LZB_EN
        ,
        .blank_out (blank_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal digits by division, blank by magnitude threshold.
    function automatic exp_t make_exp(input int v, input bit n);
        exp_t e;
        int   p;
        e.val   = v;
        e.bcd   = '0;
        e.blank = '0;
        p = 1;
        for (int d = 0; d < 5; d++) begin
            e.bcd[4*d +: 4] = 4'((v / p) % 10);
            if (d != 0 && v < p) e.blank[d] = 1'b1;
            p = p * 10;
        end
        e.sign = n && (v != 0);
        return e;
    endfunction

    // Drive one value and hold until accepted; inputs are scrambled afterwards.
    task automatic send(input int v, input bit n);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        RESULT   = 16'(v);
        NEG      = n;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk);
        sb_q.push_back(make_exp(v, n));
        #1;
        in_valid = 1'b0;
        RESULT   = 16'($urandom);
        NEG      = ~n;
    endtask

    // Wait (bounded) for out_valid; returns the number of edges waited.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        RESULT = '0;
        NEG = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bcd_out !== 20'h0) begin n_err++; $display("FAIL reset_bcd: got %h want %h", bcd_out, 20'h0); end
        n_cmp++;
        if (sign_out !== 1'b0) begin n_err++; $display("FAIL reset_sign: got %b want 0", sign_out); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
`ifdef CALC_BCD_LZB_EN
        n_cmp++;
        if (blank_out !== 5'b11110) begin n_err++; $display("FAIL reset_blank: got %b want 11110", blank_out); end
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_convert();
        int vals[10];
        bit negs[10];
        int lat;
        exp_t e;
        vals = '{440, 11926, 101, 0, 65535, 9999, 0, 0, 0, 0};
        negs = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
        for (int i = 6; i < 10; i++) begin
            vals[i] = int'($urandom_range(0, 65535));
            negs[i] = 1'($urandom);
        end
        for (int i = 0; i < 10; i++) begin
            send(vals[i], negs[i]);
            wait_out(lat);
            n_cmp++;
            if (out_valid !== 1'b1 || lat != 17) begin
                n_err++; $display("FAIL conv_latency[%0d]: got %0d edges valid=%b want 17", vals[i], lat, out_valid);
            end
            if (sb_q.size() == 0) begin
                n_err++; $display("FAIL conv_sb_empty[%0d]: got 0 entries want 1", vals[i]);
                continue;
            end
            e = sb_q.pop_front();
            n_cmp++;
            if (bcd_out !== e.bcd) begin n_err++; $display("FAIL conv_bcd[%0d]: got %h want %h", e.val, bcd_out, e.bcd); end
            n_cmp++;
            if (sign_out !== e.sign) begin n_err++; $display("FAIL conv_sign[%0d]: got %b want %b", e.val, sign_out, e.sign); end
`ifdef CALC_BCD_LZB_EN
            n_cmp++;
            if (blank_out !== e.blank) begin n_err++; $display("FAIL conv_blank[%0d]: got %b want %b", e.val, blank_out, e.blank); end
`endif
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL conv_strobe[%0d]: got %b want 0", e.val, out_valid); end
            n_cmp++;
            if (bcd_out !== e.bcd) begin n_err++; $display("FAIL conv_hold[%0d]: got %h want %h", e.val, bcd_out, e.bcd); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        exp_t e;
        send(11926, 1'b0);
        in_valid = 1'b1;
        RESULT   = 16'd999;
        NEG      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready[%0d]: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_out(lat);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL busy_timeout: got valid=%b want 1", out_valid); end
        e = sb_q.pop_front();
        n_cmp++;
        if (bcd_out !== e.bcd) begin n_err++; $display("FAIL busy_bcd: got %h want %h", bcd_out, e.bcd); end
        n_cmp++;
        if (sign_out !== e.sign) begin n_err++; $display("FAIL busy_sign: got %b want %b", sign_out, e.sign); end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL busy_idle_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        exp_t e;
        send(440, 1'b0);
        wait_out(lat);
        e = sb_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || bcd_out !== e.bcd) begin
            n_err++; $display("FAIL b2b_first: got valid=%b bcd=%h want valid=1 bcd=%h", out_valid, bcd_out, e.bcd);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_on_valid: got %b want 1", in_ready); end
        send(101, 1'b1);
        wait_out(lat);
        n_cmp++;
        if (out_valid !== 1'b1 || lat != 17) begin
            n_err++; $display("FAIL b2b_latency: got %0d edges valid=%b want 17", lat, out_valid);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (bcd_out !== e.bcd) begin n_err++; $display("FAIL b2b_bcd: got %h want %h", bcd_out, e.bcd); end
        n_cmp++;
        if (sign_out !== e.sign) begin n_err++; $display("FAIL b2b_sign: got %b want %b", sign_out, e.sign); end
`ifdef CALC_BCD_LZB_EN
        n_cmp++;
        if (blank_out !== e.blank) begin n_err++; $display("FAIL b2b_blank: got %b want %b", blank_out, e.blank); end
`endif
    endtask

    task automatic test_reset_abort();
        int lat;
        int strobes;
        exp_t e;
        send(11926, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        void'(sb_q.pop_back());
        n_cmp++;
        if (bcd_out !== 20'h0) begin n_err++; $display("FAIL abort_bcd: got %h want 00000", bcd_out); end
        n_cmp++;
        if (sign_out !== 1'b0) begin n_err++; $display("FAIL abort_sign: got %b want 0", sign_out); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) strobes++;
        end
        n_cmp++;
        if (strobes != 0) begin n_err++; $display("FAIL abort_no_strobe: got %0d strobes want 0", strobes); end
        send(11, 1'b0);
        wait_out(lat);
        n_cmp++;
        if (out_valid !== 1'b1 || lat != 17) begin
            n_err++; $display("FAIL abort_next_latency: got %0d edges valid=%b want 17", lat, out_valid);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (bcd_out !== e.bcd) begin n_err++; $display("FAIL abort_next_bcd: got %h want %h", bcd_out, e.bcd); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
